// File: rtl/nonce_dispatcher_if.sv
// Job, hash-core and status signals of the nonce dispatcher.
// The master modport is the dispatcher's view; slave is the surrounding host/core side.
interface nonce_dispatcher_if;
    logic         job_valid;
    logic         job_ready;
    logic [607:0] job_header;
    logic [255:0] job_target;
    logic [31:0]  nonce_start;
    logic [31:0]  nonce_end;
    logic         abort;
    logic         hash_start;
    logic [639:0] hash_data;
    logic [255:0] hash_result;
    logic         hash_ready;
    logic         found;
    logic [31:0]  found_nonce;
    logic [255:0] found_hash;
    logic         done;
    logic         exhausted;
    logic         timeout_err;
    logic         busy;
    logic [31:0]  hashes_done;

    modport master (
        input  job_valid, job_header, job_target, nonce_start, nonce_end, abort,
        input  hash_result, hash_ready,
        output job_ready, hash_start, hash_data,
        output found, found_nonce, found_hash, done, exhausted, timeout_err, busy, hashes_done
    );

    modport slave (
        output job_valid, job_header, job_target, nonce_start, nonce_end, abort,
        output hash_result, hash_ready,
        input  job_ready, hash_start, hash_data,
        input  found, found_nonce, found_hash, done, exhausted, timeout_err, busy, hashes_done
    );
endinterface

// File: rtl/nonce_dispatcher.sv
// Sweeps a nonce range through the SHA-256 core one hash at a time, compares each
// digest with the job target and reports hits, progress and job completion.
module nonce_dispatcher #(
    parameter bit          STOP_ON_FOUND = 1'b1,
    parameter int unsigned WATCHDOG      = 1023
) (
    input  logic                clk,
    input  logic                reset,
    nonce_dispatcher_if.master  bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DRAIN} state_t;

    // Last watchdog count still inside the window; ISSUE lasts exactly WATCHDOG cycles.
    localparam logic [9:0] WD_LIMIT = 10'(WATCHDOG - 1);

    state_t       state;
    state_t       state_nxt;
    logic [607:0] header;
    logic [255:0] target;
    logic [31:0]  nonce;
    logic [31:0]  nonce_last;
    logic [9:0]   wd;
    logic         ended;
    logic         accept;
    logic         hit;
    logic         last;
    logic         wd_expired;
    logic         stop_hit;
    logic         job_end;

    function automatic logic meets_target(input logic [255:0] digest, input logic [255:0] thr);
        return digest <= thr;
    endfunction

    assign accept     = bus.job_valid && (state == IDLE);
    assign hit        = meets_target(bus.hash_result, target);
    assign last       = (nonce == nonce_last);
    assign wd_expired = (wd == WD_LIMIT);
    assign stop_hit   = hit && STOP_ON_FOUND;
    assign job_end    = stop_hit || last || bus.abort;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE: begin
                if (bus.abort)           state_nxt = DRAIN;
                else if (bus.hash_ready) state_nxt = CAPTURE;
                else if (wd_expired)     state_nxt = DRAIN;
            end
            CAPTURE: state_nxt = DRAIN;
            DRAIN:   if (!bus.hash_ready) state_nxt = (ended || bus.abort) ? IDLE : ISSUE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.job_ready  = (state == IDLE);
        bus.busy       = (state != IDLE);
        bus.hash_start = (state == ISSUE);
        bus.hash_data  = {header, nonce};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            header          <= '0;
            target          <= '0;
            nonce           <= '0;
            nonce_last      <= '0;
            wd              <= '0;
            ended           <= 1'b0;
            bus.found       <= 1'b0;
            bus.found_nonce <= '0;
            bus.found_hash  <= '0;
            bus.done        <= 1'b0;
            bus.exhausted   <= 1'b0;
            bus.timeout_err <= 1'b0;
            bus.hashes_done <= '0;
        end else begin
            bus.found <= 1'b0;
            bus.done  <= 1'b0;
            wd        <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        header          <= bus.job_header;
                        target          <= bus.job_target;
                        nonce_last      <= bus.nonce_end;
                        nonce           <= bus.nonce_start;
                        ended           <= 1'b0;
                        bus.hashes_done <= '0;
                        bus.exhausted   <= 1'b0;
                        bus.timeout_err <= 1'b0;
                    end
                end
                ISSUE: begin
                    wd <= wd + 10'd1;
                    if (bus.abort) begin
                        ended <= 1'b1;
                    end else if (!bus.hash_ready && wd_expired) begin
                        ended           <= 1'b1;
                        bus.timeout_err <= 1'b1;
                    end
                end
                CAPTURE: begin
                    bus.hashes_done <= bus.hashes_done + 32'd1;
                    // A hit is reported even when abort arrives in the same cycle.
                    if (hit) begin
                        bus.found       <= 1'b1;
                        bus.found_nonce <= nonce;
                        bus.found_hash  <= bus.hash_result;
                    end
                    if (job_end) begin
                        ended         <= 1'b1;
                        bus.exhausted <= last && !stop_hit && !bus.abort;
                    end else begin
                        nonce <= nonce + 32'd1;
                    end
                end
                DRAIN: begin
                    if (bus.abort) ended <= 1'b1;
                    if (!bus.hash_ready && (ended || bus.abort)) bus.done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Bench for nonce_dispatcher: two instances (index 0 stops on first hit, index 1 keeps
// sweeping), each fed by a fixed-latency core model returning digest = nonce.
module tb_nonce_dispatcher;
    localparam int LAT = 70;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   jv;
    logic [607:0] hdr;
    logic [255:0] tgt;
    logic [31:0]  ns, ne;
    logic         abrt, hang;
    int           checks = 0;
    int           errors = 0;

    wire [1:0]    w_start, w_found, w_done, w_exh, w_tmo, w_busy, w_jr;
    wire [31:0]   w_fn [2];
    wire [31:0]   w_hd [2];
    wire [255:0]  w_fh [2];
    wire [639:0]  w_data [2];

    logic [31:0]  r_nonces[$], r_hits[$], m_nonces[$], m_hits[$];
    logic [31:0]  exp_fn [2];
    logic [31:0]  r_hd, r_fn;
    logic         r_exh, r_tmo, r_tmo0, r_acc_ok, r_done_jr, r_stuck, r_drop_seen, r_drop_val, m_exh;
    int           r_done, r_hdr_bad, r_fh_bad, r_maxrun;

    always #5 clk = ~clk;

    nonce_dispatcher_if bus [2] ();

    for (genvar g = 0; g < 2; g++) begin : g_dut
        int cnt;
        assign bus[g].job_valid   = jv[g];
        assign bus[g].job_header  = hdr;
        assign bus[g].job_target  = tgt;
        assign bus[g].nonce_start = ns;
        assign bus[g].nonce_end   = ne;
        assign bus[g].abort       = abrt;

        nonce_dispatcher #(.STOP_ON_FOUND(g == 0), .WATCHDOG(1023)) u_dut (
            .clk   (clk),
            .reset (rst),
            .bus   (bus[g])
        );

        always @(posedge clk) begin
            if (rst || !bus[g].hash_start) begin
                bus[g].hash_ready  <= 1'b0;
                bus[g].hash_result <= '0;
                cnt <= 0;
            end else if (!bus[g].hash_ready && !hang) begin
                if (cnt == LAT - 1) begin
                    bus[g].hash_ready  <= 1'b1;
                    bus[g].hash_result <= {224'h0, bus[g].hash_data[31:0]};
                end else begin
                    cnt <= cnt + 1;
                end
            end
        end

        assign w_start[g] = bus[g].hash_start;
        assign w_found[g] = bus[g].found;
        assign w_done[g]  = bus[g].done;
        assign w_exh[g]   = bus[g].exhausted;
        assign w_tmo[g]   = bus[g].timeout_err;
        assign w_busy[g]  = bus[g].busy;
        assign w_jr[g]    = bus[g].job_ready;
        assign w_fn[g]    = bus[g].found_nonce;
        assign w_hd[g]    = bus[g].hashes_done;
        assign w_fh[g]    = bus[g].found_hash;
        assign w_data[g]  = bus[g].hash_data;
    end

    function automatic string qstr(input logic [31:0] q[$]);
        string str = "";
        foreach (q[i]) str = {str, $sformatf("%h ", q[i])};
        return str;
    endfunction

    // Reference: walk the range arithmetically, digest equals nonce.
    task automatic model(input logic [31:0] s, input logic [31:0] e, input logic [255:0] t, input bit stop);
        logic [32:0] count;
        logic [31:0] n;
        m_nonces.delete();
        m_hits.delete();
        m_exh = 1'b1;
        count = {1'b0, 32'(e - s)} + 33'd1;
        for (longint unsigned k = 0; k < 64'(count); k++) begin
            n = s + 32'(k);
            m_nonces.push_back(n);
            if ({224'h0, n} <= t) begin
                m_hits.push_back(n);
                if (stop) begin
                    m_exh = 1'b0;
                    break;
                end
            end
        end
    endtask

    task automatic run_job(input int d, input logic [31:0] s, input logic [31:0] e, input logic [255:0] t,
                           input int ab_hash, input int ab_dly);
        logic prev;
        int   rises, run, ab_cnt;
        for (int i = 0; i < 19; i++) hdr[i*32 +: 32] = $urandom;
        ns = s; ne = e; tgt = t;
        r_nonces.delete();
        r_hits.delete();
        r_done = 0; r_hdr_bad = 0; r_fh_bad = 0; r_maxrun = 0;
        r_drop_seen = 1'b0; r_drop_val = 1'b1; r_done_jr = 1'b0;
        r_hd = '1; r_fn = '1; r_exh = 1'bx; r_tmo = 1'bx;
        prev = 1'b0; rises = 0; run = 0; ab_cnt = 0;
        @(negedge clk); jv[d] = 1'b1;
        @(negedge clk); jv[d] = 1'b0;
        r_acc_ok = w_start[d] && w_busy[d] && !w_jr[d];
        r_tmo0   = w_tmo[d];
        for (int cyc = 0; cyc < 20000 && r_done == 0; cyc++) begin
            if (abrt) begin
                abrt = 1'b0;
                r_drop_seen = 1'b1;
                r_drop_val  = w_start[d];
            end
            if (ab_cnt > 0) begin
                ab_cnt--;
                if (ab_cnt == 0) abrt = 1'b1;
            end
            if (w_start[d] && !prev) begin
                rises++;
                r_nonces.push_back(w_data[d][31:0]);
                if (w_data[d][639:32] !== hdr) r_hdr_bad++;
                if (rises == ab_hash) ab_cnt = ab_dly;
            end
            run = w_start[d] ? run + 1 : 0;
            if (run > r_maxrun) r_maxrun = run;
            if (w_found[d]) begin
                r_hits.push_back(w_fn[d]);
                if (w_fh[d] !== {224'h0, w_fn[d]}) r_fh_bad++;
            end
            if (w_done[d]) begin
                r_done++;
                r_done_jr = w_jr[d];
                r_hd = w_hd[d]; r_exh = w_exh[d]; r_tmo = w_tmo[d]; r_fn = w_fn[d];
            end
            prev = w_start[d];
            if (r_done == 0) @(negedge clk);
        end
        r_stuck = (r_done == 0);
        repeat (3) begin
            @(negedge clk);
            if (w_done[d]) r_done++;
        end
    endtask

    task automatic test_job(input string name, input int d, input logic [31:0] s, input logic [31:0] e,
                            input logic [255:0] t);
        model(s, e, t, d == 0);
        run_job(d, s, e, t, 0, 0);
        if (m_hits.size() != 0) exp_fn[d] = m_hits[m_hits.size()-1];
        checks++; if (r_stuck) begin errors++; $display("FAIL %s done: no done pulse within budget", name); end
        checks++; if (r_acc_ok !== 1'b1) begin errors++; $display("FAIL %s accept: start/busy/job_ready wrong in cycle after accept", name); end
        checks++; if (qstr(r_nonces) != qstr(m_nonces)) begin
            errors++; $display("FAIL %s nonces: got %s want %s", name, qstr(r_nonces), qstr(m_nonces)); end
        checks++; if (qstr(r_hits) != qstr(m_hits)) begin
            errors++; $display("FAIL %s hits: got %s want %s", name, qstr(r_hits), qstr(m_hits)); end
        checks++; if (r_fh_bad != 0 || r_hdr_bad != 0) begin
            errors++; $display("FAIL %s data: found_hash bad %0d header bad %0d want 0 0", name, r_fh_bad, r_hdr_bad); end
        checks++; if (r_hd !== 32'(m_nonces.size())) begin
            errors++; $display("FAIL %s hashes_done: got %0d want %0d", name, r_hd, m_nonces.size()); end
        checks++; if (r_exh !== m_exh) begin errors++; $display("FAIL %s exhausted: got %b want %b", name, r_exh, m_exh); end
        checks++; if (r_tmo !== 1'b0) begin errors++; $display("FAIL %s timeout_err: got %b want 0", name, r_tmo); end
        checks++; if (r_done != 1 || r_done_jr !== 1'b1) begin
            errors++; $display("FAIL %s done: pulses %0d job_ready %b want 1 1", name, r_done, r_done_jr); end
        checks++; if (r_fn !== exp_fn[d]) begin errors++; $display("FAIL %s found_nonce: got %h want %h", name, r_fn, exp_fn[d]); end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            checks++; if ({w_start[d], w_found[d], w_done[d], w_exh[d], w_tmo[d], w_busy[d], w_jr[d]} !== 7'b0000001) begin
                errors++; $display("FAIL reset flags[%0d]: got %b want 0000001", d,
                    {w_start[d], w_found[d], w_done[d], w_exh[d], w_tmo[d], w_busy[d], w_jr[d]}); end
            checks++; if (w_data[d] !== '0) begin errors++; $display("FAIL reset hash_data[%0d]: got %h want 0", d, w_data[d]); end
            checks++; if (w_fn[d] !== '0 || w_fh[d] !== '0 || w_hd[d] !== '0) begin
                errors++; $display("FAIL reset counters[%0d]: fn %h fh %h hd %h want 0", d, w_fn[d], w_fh[d], w_hd[d]); end
        end
    endtask

    task automatic test_stop_on_found();
        test_job("stop_found", 0, 32'd0, 32'd9, 256'h5);
        checks++; if (r_hd !== 32'd1 || r_fn !== 32'd0) begin
            errors++; $display("FAIL stop_found fixed: hd %0d fn %h want 1 0", r_hd, r_fn); end
    endtask

    task automatic test_exhaust();
        test_job("exhaust", 0, 32'd3, 32'd7, 256'h0);
        checks++; if (qstr(r_nonces) != "00000003 00000004 00000005 00000006 00000007 ") begin
            errors++; $display("FAIL exhaust fixed nonces: got %s want 3..7", qstr(r_nonces)); end
    endtask

    task automatic test_wrap();
        test_job("wrap", 1, 32'hFFFFFFFE, 32'h00000001, 256'h0);
        checks++; if (qstr(r_nonces) != "fffffffe ffffffff 00000000 00000001 " || r_exh !== 1'b1) begin
            errors++; $display("FAIL wrap fixed: nonces %s exh %b want fffffffe..00000001 1", qstr(r_nonces), r_exh); end
    endtask

    task automatic test_no_stop();
        test_job("no_stop", 1, 32'd0, 32'd4, 256'h2);
        checks++; if (qstr(r_hits) != "00000000 00000001 00000002 " || r_hd !== 32'd5) begin
            errors++; $display("FAIL no_stop fixed: hits %s hd %0d want 0 1 2 / 5", qstr(r_hits), r_hd); end
    endtask

    task automatic test_random();
        int d;
        logic [31:0] s, e;
        logic [255:0] t;
        for (int i = 0; i < 6; i++) begin
            d = $urandom_range(0, 1);
            s = ($urandom_range(0, 2) == 0) ? 32'hFFFFFFFF - 32'($urandom_range(0, 3)) : $urandom;
            e = s + 32'($urandom_range(0, 4));
            case ($urandom_range(0, 2))
                0:       t = {224'h0, s + 32'($urandom_range(0, 4))};
                1:       t = {$urandom | 32'h1, 224'h0};
                default: t = {224'h0, s} - 256'd1;
            endcase
            test_job($sformatf("random%0d", i), d, s, e, t);
        end
    endtask

    task automatic test_watchdog();
        hang = 1'b1;
        run_job(0, 32'h100, 32'h1FF, '1, 0, 0);
        hang = 1'b0;
        checks++; if (r_stuck) begin errors++; $display("FAIL watchdog done: no done pulse within budget"); end
        checks++; if (r_maxrun != 1023) begin errors++; $display("FAIL watchdog start_len: got %0d want 1023", r_maxrun); end
        checks++; if (r_tmo !== 1'b1 || r_exh !== 1'b0 || r_hd !== 32'd0 || r_done != 1) begin
            errors++; $display("FAIL watchdog status: tmo %b exh %b hd %0d done %0d want 1 0 0 1", r_tmo, r_exh, r_hd, r_done); end
        test_job("wd_next", 0, 32'h20, 32'h21, 256'h0);
        checks++; if (r_tmo0 !== 1'b0) begin errors++; $display("FAIL wd_next clear: timeout_err after accept got %b want 0", r_tmo0); end
    endtask

    task automatic test_abort();
        run_job(1, 32'd0, 32'd99, 256'h0, 3, 10);
        exp_fn[1] = 32'd0;
        checks++; if (r_stuck) begin errors++; $display("FAIL abort done: no done pulse within budget"); end
        checks++; if (r_drop_seen !== 1'b1 || r_drop_val !== 1'b0) begin
            errors++; $display("FAIL abort drop: seen %b hash_start %b want 1 0", r_drop_seen, r_drop_val); end
        checks++; if (qstr(r_nonces) != "00000000 00000001 00000002 " || qstr(r_hits) != "00000000 ") begin
            errors++; $display("FAIL abort seq: nonces %s hits %s want 0 1 2 / 0", qstr(r_nonces), qstr(r_hits)); end
        checks++; if (r_hd !== 32'd2 || r_exh !== 1'b0 || r_tmo !== 1'b0 || r_done != 1) begin
            errors++; $display("FAIL abort status: hd %0d exh %b tmo %b done %0d want 2 0 0 1", r_hd, r_exh, r_tmo, r_done); end
    endtask

    task automatic test_reset_mid_job();
        int bad;
        test_job("pre_reset", 0, 32'h55, 32'h55, '1);
        ns = 32'd0; ne = 32'd9; tgt = '0;
        @(negedge clk); jv[0] = 1'b1;
        @(negedge clk); jv[0] = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (w_start[0] !== 1'b1) begin errors++; $display("FAIL reset_mid issue: hash_start %b want 1", w_start[0]); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({w_start[0], w_found[0], w_done[0], w_exh[0], w_tmo[0], w_busy[0], w_jr[0]} !== 7'b0000001) begin
            errors++; $display("FAIL reset_mid flags: got %b want 0000001",
                {w_start[0], w_found[0], w_done[0], w_exh[0], w_tmo[0], w_busy[0], w_jr[0]}); end
        checks++; if (w_data[0] !== '0 || w_fn[0] !== '0 || w_fh[0] !== '0 || w_hd[0] !== '0) begin
            errors++; $display("FAIL reset_mid values: data %h fn %h fh %h hd %h want 0", w_data[0], w_fn[0], w_fh[0], w_hd[0]); end
        rst = 1'b0;
        exp_fn[0] = '0; exp_fn[1] = '0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (w_done[0] || !w_jr[0] || w_start[0]) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL reset_mid idle: bad cycles %0d want 0", bad); end
    endtask

    initial begin
        rst = 1'b1; jv = '0; hdr = '0; tgt = '0; ns = '0; ne = '0; abrt = 1'b0; hang = 1'b0;
        exp_fn[0] = '0; exp_fn[1] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_stop_on_found();
        test_exhaust();
        test_wrap();
        test_no_stop();
        test_random();
        test_watchdog();
        test_abort();
        test_reset_mid_job();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nonce_dispatcher.md
# nonce_dispatcher

Upstream job controller for the SHA-256 hashing core. Accepts a mining job (76-byte header prefix, 256-bit target, nonce range), and sweeps the nonce range, one nonce per hash. For each nonce it assembles the 640-bit block, drives the core's start/ready handshake and captures the result. It compares the result against the target and reports hits, progress and completion to the host-side logic.

## Interface
- STOP_ON_FOUND, 1, 1: end job at first hit; 0: report hit and keep sweeping
- WATCHDOG, 1023, max cycles allowed between hash_start rising and hash_ready high; 10-bit counter
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- job_valid  in  1  job offered
- job_ready  out  1  high only in IDLE; job accepted on job_valid & job_ready
- job_header  in  608  header bytes 0..75, MSB first
- job_target  in  256  unsigned threshold
- nonce_start  in  32  first nonce, inclusive
- nonce_end  in  32  last nonce, inclusive
- abort  in  1  cancel current job
- hash_start  out  1  request to core
- hash_data  out  640  {header, nonce}; nonce in bits [31:0]
- hash_result  in  256  core digest
- hash_ready  in  1  core done flag
- found  out  1  one-cycle pulse per hit
- found_nonce  out  32  nonce of most recent hit
- found_hash  out  256  digest of most recent hit
- done  out  1  one-cycle pulse at job end
- exhausted  out  1  last job ended by covering the full range
- timeout_err  out  1  sticky: last job ended by watchdog
- busy  out  1  high in every state except IDLE
- hashes_done  out  32  hashes completed in current/last job, wraps mod 2^32

## Operation
- States: IDLE, ISSUE, CAPTURE, DRAIN.
- IDLE:
  - On accept, latch header, target and nonce_end.
  - Set nonce := nonce_start.
  - Clear hashes_done, exhausted and timeout_err.
  - Go to ISSUE.
- ISSUE:
  - hash_start=1. hash_data={header, nonce}, stable while in ISSUE.
  - Watchdog counts up from 0.
  - hash_ready=1 sampled -> CAPTURE.
  - Watchdog reaches WATCHDOG -> set timeout_err -> DRAIN.
- CAPTURE (1 cycle):
  - hash_start=0.
  - Increment hashes_done.
  - If hash_result <= job_target (256-bit unsigned): found pulse, load found_nonce and found_hash.
  - Job ends if (hit and STOP_ON_FOUND=1) or nonce == nonce_end. A range end with no stopping hit sets exhausted.
  - Otherwise nonce := nonce + 1 mod 2^32.
  - Next state is always DRAIN.
- DRAIN:
  - hash_start=0. Wait until hash_ready=0, so the core has returned to idle.
  - Then ISSUE if the job continues; otherwise IDLE with a done pulse.
- Wrap-around: nonce_end < nonce_start is legal. The sweep passes FFFFFFFF -> 00000000. Range size = (nonce_end - nonce_start mod 2^32) + 1. nonce_start == nonce_end gives exactly one hash.
- abort:
  - In ISSUE or CAPTURE: go to DRAIN with the job marked ended. This is not exhausted and not a timeout.
  - In DRAIN: the job is marked ended.
  - In IDLE: ignored.
  - A hit captured in the same cycle as abort is still reported.
- found_nonce and found_hash hold until the next hit or reset, across jobs.

## Timing
- Reset values:
  - Outputs: hash_start 0, hash_data 0, found 0, done 0, found_nonce 0, found_hash 0, exhausted 0, timeout_err 0, busy 0, hashes_done 0.
  - Internal: state IDLE.
  - job_ready is 1 from the first cycle after reset.
- Reset mid-job: all of the above apply at the next edge. No done pulse. The core must be reset alongside.
- Accept at edge N: hash_start=1 from cycle N+1.
- Per hash: core latency + 1 (CAPTURE) + DRAIN wait (≥1 cycle) + 1 to re-assert start.
- done pulses in the cycle after DRAIN sees hash_ready=0. job_ready=1 in that same cycle.
- found is coincident with the cycle after CAPTURE, i.e. the first DRAIN cycle (registered).
- job_valid is ignored while busy=1.

## Test plan
- Behavioral core model, fixed 70-cycle latency, digest = {224'h0, nonce}. Target 256'h5, range 0..9, STOP_ON_FOUND=1 -> found at nonce 0, found_nonce=0, hashes_done=1, exhausted=0, done pulse.
- Same model, target 0, range 3..7 -> no found. hashes_done=5, exhausted=1. hash_data[31:0] sequence 3,4,5,6,7.
- Wrap: target 0, range FFFFFFFE..00000001 -> nonces FFFFFFFE, FFFFFFFF, 0, 1. hashes_done=4, exhausted=1.
- STOP_ON_FOUND=0, target 256'h2, range 0..4 -> found pulses for nonces 0,1,2. found_nonce=2, hashes_done=5, exhausted=1.
- Model never raises hash_ready, WATCHDOG=1023 -> hash_start high 1023 cycles, then timeout_err=1 and done pulse. Next accepted job clears timeout_err.
- abort 10 cycles into the third hash of range 0..99 -> hash_start drops next cycle, done after model ready low. hashes_done=2, exhausted=0. Reset asserted mid-ISSUE -> all outputs at reset values next cycle.
